// File: rtl/serdes_pkg.sv
// Shared SerDes framing definitions: FSM state encoding and line levels,
// used by both the frame receiver and the frame transmitter.
package serdes_pkg;

    localparam int DEFAULT_DATA_W = 8;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/serdes_rx_fifo.sv
// Synchronous FIFO holding completed receive words. A push when full is
// accepted only if a pop happens on the same cycle; otherwise it is ignored.
module serdes_rx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              sclk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = pop_i && !w_empty;
    assign w_push  = push_i && (!w_full || w_pop);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge sclk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; emptiness is tracked by the
    // count, and the output is forced to zero while empty.
    always_ff @(posedge sclk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= push_data_i;
    end

    assign data_o  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign full_o  = w_full;
    assign empty_o = w_empty;

endmodule

// File: rtl/serdes_frame_rx.sv
// Framed serial receiver: start bit, LSB-first payload, optional even parity
// (enabled by defining SERDES_RX_PARITY_EN), stop bit; words queued in a FIFO.
module serdes_frame_rx
    import serdes_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              sclk_i,
    input  logic              rst_i,
    input  logic              data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              frame_err_o,
    output logic              ovf_o,
    output logic              busy_o
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [DATA_W-1:0] r_shift;
    logic              r_par_err;
    logic              r_frame_err;
    logic              r_ovf;

    logic w_stop_cycle;
    logic w_good;
    logic w_push;
    logic w_bad;
    logic w_drop;
    logic w_full;
    logic w_empty;
    logic w_pop;

    assign w_stop_cycle = valid_i && (r_state == ST_STOP);
    assign w_good       = (data_i == STOP_BIT) && !r_par_err;
    assign w_push       = w_stop_cycle && w_good;
    assign w_bad        = w_stop_cycle && !w_good;
    assign w_pop        = !w_empty && ready_i;
    // A full FIFO only makes room if the consumer pops on the push cycle.
    assign w_drop       = w_push && w_full && !w_pop;

    always_ff @(posedge sclk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_par_err   <= 1'b0;
            r_frame_err <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_frame_err <= w_bad;
            r_ovf       <= w_drop;
            if (valid_i) begin
                case (r_state)
                    ST_IDLE: begin
                        if (data_i == START_BIT) begin
                            r_state   <= ST_DATA;
                            r_bit_cnt <= '0;
                            r_par_err <= 1'b0;
                        end
                    end
                    ST_DATA: begin
                        r_shift[r_bit_cnt] <= data_i;
                        if (r_bit_cnt == LAST_BIT) begin
                            r_bit_cnt <= '0;
`ifdef SERDES_RX_PARITY_EN
                            r_state   <= ST_PARITY;
`else
                            r_state   <= ST_STOP;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        end
                    end
`ifdef SERDES_RX_PARITY_EN
                    ST_PARITY: begin
                        // Even parity: the parity bit equals the XOR of the payload.
                        r_par_err <= (data_i != ^r_shift);
                        r_state   <= ST_STOP;
                    end
`endif
                    ST_STOP: r_state <= ST_IDLE;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    serdes_rx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .sclk_i      (sclk_i),
        .rst_i       (rst_i),
        .push_i      (w_push),
        .push_data_i (r_shift),
        .pop_i       (ready_i),
        .data_o      (data_o),
        .full_o      (w_full),
        .empty_o     (w_empty)
    );

    assign ready_o     = !w_full;
    assign valid_o     = !w_empty;
    assign frame_err_o = r_frame_err;
    assign ovf_o       = r_ovf;
    assign busy_o      = (r_state != ST_IDLE);

endmodule
